// File: rtl/all_led_sequencer_pkg.sv
// rtl/all_led_sequencer_pkg.sv - PCA register map constants and fan-out FSM encodings
package all_led_sequencer_pkg;

    localparam logic [7:0] LED_BASE     = 8'h06;
    localparam logic [7:0] ALL_LED_BASE = 8'hFA;
    localparam int         LED_STRIDE   = 4;
    localparam int         LED_COUNT    = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        FANOUT = 1'b1
    } state_t;

    function automatic logic [1:0] lowest_bit(input logic [3:0] mask);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/all_led_sequencer.sv
// rtl/all_led_sequencer.sv - register write arbiter fanning ALL_LED writes out to every LEDn byte
module all_led_sequencer
    import all_led_sequencer_pkg::*;
#(
    parameter int         LED_COUNT_P    = LED_COUNT,
    parameter logic [7:0] LED_BASE_P     = LED_BASE,
    parameter logic [7:0] ALL_LED_BASE_P = ALL_LED_BASE
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] host_id_i,
    input  logic [7:0] host_value_i,
    input  logic       host_we_i,
    output logic [7:0] reg_id_o,
    output logic [7:0] reg_value_o,
    output logic       reg_we_o,
    output logic       busy_o
);

    localparam int NW = $clog2(LED_COUNT_P);

    state_t          state;
    logic [3:0]      pending;
    logic [7:0]      value_r [4];
    logic [NW-1:0]   n;
    logic [1:0]      k;

    logic [7:0]      all_diff;
    logic            is_all;
    logic [1:0]      host_k;
    logic [3:0]      pend_set;
    logic [1:0]      next_k;
    logic [3:0]      pend_clr;
    logic [7:0]      led_id;

    always_comb begin
        all_diff = host_id_i - ALL_LED_BASE_P;
        is_all   = host_we_i && (all_diff[7:2] == 6'd0);
        host_k   = all_diff[1:0];
        pend_set = pending | (is_all ? (4'b0001 << host_k) : 4'b0000);
        next_k   = lowest_bit(pend_set);
        pend_clr = pend_set & ~(4'b0001 << next_k);
        led_id   = LED_BASE_P + 8'(LED_STRIDE) * 8'(n) + 8'(k);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            pending     <= 4'd0;
            n           <= '0;
            k           <= 2'd0;
            reg_id_o    <= 8'd0;
            reg_value_o <= 8'd0;
            reg_we_o    <= 1'b0;
            busy_o      <= 1'b0;
            for (int i = 0; i < 4; i++) value_r[i] <= 8'd0;
        end else begin
            reg_we_o <= 1'b0;
            if (host_we_i) begin
                reg_we_o    <= 1'b1;
                reg_id_o    <= host_id_i;
                reg_value_o <= host_value_i;
                if (is_all) value_r[host_k] <= host_value_i;
            end

            case (state)
                IDLE: begin
                    if (pend_set != 4'd0) begin
                        k       <= next_k;
                        n       <= '0;
                        pending <= pend_clr;
                        state   <= FANOUT;
                        busy_o  <= 1'b1;
                    end else begin
                        pending <= pend_set;
                        busy_o  <= 1'b0;
                    end
                end
                FANOUT: begin
                    if (host_we_i) begin
                        // Host owns this slot; the channel index waits for the next free cycle.
                        pending <= pend_set;
                        busy_o  <= 1'b1;
                    end else begin
                        reg_we_o    <= 1'b1;
                        reg_id_o    <= led_id;
                        reg_value_o <= value_r[k];
                        if (n == NW'(LED_COUNT_P - 1)) begin
                            if (pend_set != 4'd0) begin
                                k       <= next_k;
                                n       <= '0;
                                pending <= pend_clr;
                                busy_o  <= 1'b1;
                            end else begin
                                pending <= pend_set;
                                state   <= IDLE;
                                busy_o  <= 1'b0;
                            end
                        end else begin
                            n       <= n + 1'b1;
                            pending <= pend_set;
                            busy_o  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_all_led_sequencer.sv
// tb/tb_all_led_sequencer.sv - scoreboard bench for all_led_sequencer
module tb_all_led_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] host_id = 8'd0;
    logic [7:0] host_value = 8'd0;
    logic       host_we = 1'b0;
    logic [7:0] reg_id;
    logic [7:0] reg_value;
    logic       reg_we;
    logic       busy;

    all_led_sequencer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .host_id_i   (host_id),
        .host_value_i(host_value),
        .host_we_i   (host_we),
        .reg_id_o    (reg_id),
        .reg_value_o (reg_value),
        .reg_we_o    (reg_we),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_q [$];
    logic [7:0]  store [256];

    // Reference: an active pass walks 16 channels one free slot at a time; queued bytes wait in a set.
    bit        m_active;
    int        m_k;
    int        m_n;
    bit        m_pend [4];
    logic [7:0] m_val [4];
    bit        m_busy;

    function automatic void model_reset();
        m_active = 0; m_k = 0; m_n = 0; m_busy = 0;
        for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_val[i] = 8'd0; end
        exp_q.delete();
    endfunction

    function automatic void model_step(input bit we, input logic [7:0] id, input logic [7:0] v);
        int b;
        if (we) begin
            exp_q.push_back({id, v});
            if (id >= 8'hFA && id <= 8'hFD) begin
                b = int'(id) - 'hFA;
                m_val[b] = v;
                m_pend[b] = 1;
            end
        end else if (m_active) begin
            exp_q.push_back({8'(6 + 4 * m_n + m_k), m_val[m_k]});
            m_n++;
            if (m_n == 16) m_active = 0;
        end
        if (!m_active) begin
            for (int i = 3; i >= 0; i--) if (m_pend[i]) b = i;
            if (m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3]) begin
                m_active = 1; m_k = b; m_n = 0; m_pend[b] = 0;
            end
        end
        m_busy = m_active || m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3];
    endfunction

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic cyc(input bit we, input logic [7:0] id, input logic [7:0] v);
        @(negedge clk);
        host_we = we; host_id = id; host_value = v;
        @(posedge clk);
        model_step(we, id, v);
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) cyc(1'b0, 8'd0, 8'd0);
    endtask

    task automatic check_byte(input int kb, input logic [7:0] v);
        for (int i = 0; i < 16; i++)
            check($sformatf("led%0d_byte%0d", i, kb), int'(store[6 + 4 * i + kb]), int'(v));
    endtask

    // Monitor: every DUT write must match the next scoreboard entry.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("busy", int'(busy), int'(m_busy));
                if (reg_we) begin
                    store[reg_id] = reg_value;
                    if (exp_q.size() == 0) begin
                        check("unexpected_write_id", int'(reg_id), 'h100);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_id", int'(reg_id), int'(e[15:8]));
                        check("write_value", int'(reg_value), int'(e[7:0]));
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] rid;
        for (int i = 0; i < 256; i++) store[i] = 8'd0;
        model_reset();
        #1;
        check("reset_we", int'(reg_we), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_id", int'(reg_id), 0);
        check("reset_value", int'(reg_value), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        cyc(1'b1, 8'h00, 8'h11);
        idle(5);
        check("store_00", int'(store[8'h00]), 'h11);

        cyc(1'b1, 8'hFC, 8'hAB);
        idle(20);
        check_byte(2, 8'hAB);
        check("store_fc", int'(store[8'hFC]), 'hAB);

        cyc(1'b1, 8'hFA, 8'h01);
        idle(4);
        cyc(1'b1, 8'h00, 8'h20);
        idle(25);
        check_byte(0, 8'h01);
        check("store_00_b", int'(store[8'h00]), 'h20);

        cyc(1'b1, 8'hFD, 8'h10);
        idle(3);
        cyc(1'b1, 8'hFB, 8'h05);
        idle(40);
        check_byte(3, 8'h10);
        check_byte(1, 8'h05);

        cyc(1'b1, 8'hFA, 8'h01);
        idle(6);
        cyc(1'b1, 8'hFA, 8'h02);
        idle(40);
        check_byte(0, 8'h02);

        cyc(1'b1, 8'hFA, 8'h33);
        idle(9);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("abort_we", int'(reg_we), 0);
        check("abort_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        host_we = 1'b0;
        rst_n = 1'b1;
        idle(20);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3) == 0) begin
                if ($urandom_range(1) == 0) rid = 8'hFA + 8'($urandom_range(3));
                else rid = 8'($urandom_range(255));
                cyc(1'b1, rid, 8'($urandom_range(255)));
            end else begin
                idle(1);
            end
        end
        idle(120);
        check("queue_drained", exp_q.size(), 0);
        check("final_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
